// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution output stage:
//   - state_e      : packer FSM states
//   - DEF_*        : default widths/geometry used by the packer and its users
//   - quantize()   : shift + ReLU + saturate at the default widths, for callers
//                    that handle a single result outside the packer datapath
// -----------------------------------------------------------------------------
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int DEF_ACC_W  = 24;
    localparam int DEF_OUT_W  = 8;
    localparam int DEF_LANES  = 4;
    localparam int DEF_SHIFT  = 4;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_CNT_W  = 12;

    // Arithmetic shift, then clamp to [0, 2^OUT_W-1].
    function automatic logic [DEF_OUT_W-1:0] quantize(input logic signed [DEF_ACC_W-1:0] acc);
        logic signed [DEF_ACC_W-1:0] q;
        q = acc >>> DEF_SHIFT;
        if (q[DEF_ACC_W-1]) begin
            return '0;
        end else if (|q[DEF_ACC_W-2:DEF_OUT_W]) begin
            return '1;
        end
        return q[DEF_OUT_W-1:0];
    endfunction

endpackage

// File: rtl/conv_result_packer_if.sv
// -----------------------------------------------------------------------------
// conv_result_packer_if
// Bundles the layer control, result stream and memory write bus of the packer.
//   master : drives start/base_addr/num_results, in_valid/in_data, mem_ready
//   slave  : the packer; drives in_ready, mem_wr_en/mem_addr/mem_wdata,
//            busy and done
// -----------------------------------------------------------------------------
interface conv_result_packer_if
    import conv_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
);

    logic                     start;
    logic [ADDR_W-1:0]        base_addr;
    logic [CNT_W-1:0]         num_results;
    logic                     in_valid;
    logic [ACC_W-1:0]         in_data;
    logic                     in_ready;
    logic                     mem_wr_en;
    logic [ADDR_W-1:0]        mem_addr;
    logic [LANES*OUT_W-1:0]   mem_wdata;
    logic                     mem_ready;
    logic                     busy;
    logic                     done;

    modport master (
        output start, base_addr, num_results, in_valid, in_data, mem_ready,
        input  in_ready, mem_wr_en, mem_addr, mem_wdata, busy, done
    );

    modport slave (
        input  start, base_addr, num_results, in_valid, in_data, mem_ready,
        output in_ready, mem_wr_en, mem_addr, mem_wdata, busy, done
    );

endinterface

// File: rtl/conv_quantizer.sv
// -----------------------------------------------------------------------------
// conv_quantizer
// Purely combinational requantizer: signed ACC_W result -> unsigned OUT_W byte.
//   data_i : signed accumulator result
//   data_o : (data_i >>> SHIFT) clamped to [0, 2^OUT_W-1]
// -----------------------------------------------------------------------------
module conv_quantizer
    import conv_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic signed [ACC_W-1:0] data_i,
    output logic        [OUT_W-1:0] data_o
);

    logic signed [ACC_W-1:0] shifted;

    assign shifted = data_i >>> SHIFT;

    // Sign bit set -> negative -> ReLU to 0; any set bit above the output
    // width on a positive value -> saturate.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        data_o = shifted[OUT_W-1:0];
        if (shifted[ACC_W-1]) begin
            data_o = '0;
        end else if (|shifted[ACC_W-2:OUT_W]) begin
            data_o = '1;
        end
    end

endmodule

// File: rtl/conv_result_packer.sv
// -----------------------------------------------------------------------------
// conv_result_packer
// Requantizes accumulator results, packs LANES bytes per word and writes the
// words to consecutive addresses from a latched base; a partial last word is
// zero-padded. done pulses for one cycle when the layer completes.
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : conv_result_packer_if.slave (control, result stream, memory bus)
// All outputs come from registered state only.
// -----------------------------------------------------------------------------
module conv_result_packer
    import conv_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int LANES  = DEF_LANES,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_result_packer_if.slave  bus
);

    localparam int WORD_W = LANES * OUT_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_e              state_q, state_d;
    logic [LANE_W-1:0]   lane_cnt_q, lane_cnt_d;
    logic [CNT_W-1:0]    res_cnt_q, res_cnt_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   widx_q, widx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;

    logic [OUT_W-1:0]    q_byte;
    logic [WORD_W-1:0]   pack_ins;
    logic                xfer;
    logic                last_in_word;

    conv_quantizer #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_quant (
        .data_i (bus.in_data),
        .data_o (q_byte)
    );

    // in_ready is exactly "state is COLLECT", so this is the accepted-input strobe.
    assign xfer         = (state_q == ST_COLLECT) && bus.in_valid;
    assign last_in_word = (lane_cnt_q == LANE_W'(LANES - 1)) ||
                          ((res_cnt_q + CNT_W'(1)) == num_q);

    // Pack register with the incoming byte dropped into the current lane; this
    // is also what gets written when the word closes on this transfer.
    always_comb begin
        pack_ins = pack_q;
        for (int l = 0; l < LANES; l++) begin
            if (lane_cnt_q == LANE_W'(l)) begin
                pack_ins[l*OUT_W +: OUT_W] = q_byte;
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.num_results != '0) ? ST_COLLECT : ST_DONE;
                end
            end
            ST_COLLECT: begin
                if (xfer && last_in_word) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // res_cnt already counts every result packed into this word.
                if (bus.mem_ready) begin
                    state_d = (res_cnt_q == num_q) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.in_ready  = (state_q == ST_COLLECT);
        bus.mem_wr_en = (state_q == ST_WRITE);
        bus.busy      = (state_q != ST_IDLE);
        bus.done      = (state_q == ST_DONE);
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // ---------------- Datapath next state ----------------
    always_comb begin
        lane_cnt_d = lane_cnt_q;
        res_cnt_d  = res_cnt_q;
        num_d      = num_q;
        base_d     = base_q;
        widx_d     = widx_q;
        addr_d     = addr_q;
        pack_d     = pack_q;
        wdata_d    = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && (bus.num_results != '0)) begin
                    base_d     = bus.base_addr;
                    num_d      = bus.num_results;
                    lane_cnt_d = '0;
                    res_cnt_d  = '0;
                    widx_d     = '0;
                    pack_d     = '0;
                end
            end
            ST_COLLECT: begin
                if (xfer) begin
                    pack_d     = pack_ins;
                    lane_cnt_d = lane_cnt_q + LANE_W'(1);
                    res_cnt_d  = res_cnt_q + CNT_W'(1);
                    if (last_in_word) begin
                        wdata_d = pack_ins;
                        addr_d  = base_q + widx_q;   // wraps modulo 2^ADDR_W
                    end
                end
            end
            ST_WRITE: begin
                if (bus.mem_ready) begin
                    widx_d     = widx_q + ADDR_W'(1);
                    pack_d     = '0;
                    lane_cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the pack register is reset along with the counters; a
            // partial word from an aborted layer must never leak into the
            // next layer's zero-padded lanes.
            lane_cnt_q <= '0;
            res_cnt_q  <= '0;
            num_q      <= '0;
            base_q     <= '0;
            widx_q     <= '0;
            addr_q     <= '0;
            pack_q     <= '0;
            wdata_q    <= '0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            res_cnt_q  <= res_cnt_d;
            num_q      <= num_d;
            base_q     <= base_d;
            widx_q     <= widx_d;
            addr_q     <= addr_d;
            pack_q     <= pack_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_conv_result_packer.sv
// -----------------------------------------------------------------------------
// tb_conv_result_packer
// Directed sequence of layers with randomized data/handshakes. Expected words
// are built from the input list with plain arithmetic (floor divide by 16,
// clamp, group by four) and compared with the writes the bus accepted.
// -----------------------------------------------------------------------------
module tb_conv_result_packer;

    logic clk = 1'b0;
    logic rst;

    int n_cmp  = 0;
    int n_fail = 0;

    int          stim_q[$];
    logic [31:0] got_data[$];
    logic [15:0] got_addr[$];

    conv_result_packer_if bus ();

    conv_result_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Floor division by 2^4, then ReLU and saturation to a byte.
    function automatic int ref_quant(input int x);
        int q;
        if (x >= 0) q = x / 16;
        else        q = -((-x + 15) / 16);
        if (q < 0)   return 0;
        if (q > 255) return 255;
        return q;
    endfunction

    function automatic int rand_acc();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 8000)) - 2000;
        return int'($urandom_range(0, 24'hFFFFFF)) - 8388608;
    endfunction

    task automatic fill_random(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(rand_acc());
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
        check({tag, "_mem_wr_en"}, 64'(bus.mem_wr_en), 64'd0);
        check({tag, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
        check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        check({tag, "_busy"},      64'(bus.busy),      64'd0);
        check({tag, "_done"},      64'(bus.done),      64'd0);
    endtask

    // ready_mode: 0 = mem_ready always 1, 1 = random, 2 = stall first write 5 cycles
    task automatic run_layer(input string tag, input logic [15:0] base, input int n,
                             input int ready_mode, input bit glitch);
        logic [31:0] exp_data[$];
        logic [15:0] exp_addr[$];
        logic [31:0] word, snap_d;
        logic [15:0] snap_a;
        int nwords, idx, cycles, budget, stall_left;
        bit prev_final, snapped, done_seen;

        nwords = (n + 3) / 4;
        for (int w = 0; w < nwords; w++) begin
            word = '0;
            for (int l = 0; l < 4; l++) begin
                if (w * 4 + l < n) word = word | (32'(ref_quant(stim_q[w * 4 + l])) << (8 * l));
            end
            exp_data.push_back(word);
            exp_addr.push_back(16'(int'(base) + w));
        end
        got_data.delete();
        got_addr.delete();

        @(negedge clk);
        bus.start       = 1'b1;
        bus.base_addr   = base;
        bus.num_results = 12'(n);
        bus.in_valid    = 1'b0;
        bus.mem_ready   = 1'b0;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.base_addr   = 16'($urandom);
        bus.num_results = 12'($urandom);
        check({tag, "_busy_after_start"},     64'(bus.busy),     64'd1);
        check({tag, "_in_ready_after_start"}, 64'(bus.in_ready), 64'd1);

        idx = 0; cycles = 0; budget = 40 * n + 50;
        stall_left = (ready_mode == 2) ? 5 : 0;
        prev_final = 1'b0; snapped = 1'b0;
        while (cycles < budget) begin
            if (bus.done) break;
            bus.start = glitch && (cycles == 3);
            if (glitch && cycles == 3) begin
                bus.base_addr   = 16'h7777;
                bus.num_results = 12'd2;
            end
            bus.in_valid = (idx < n) && (ready_mode == 0 || $urandom_range(0, 3) != 0);
            bus.in_data  = (idx < n) ? 24'(stim_q[idx]) : 24'($urandom);
            if (ready_mode == 2 && bus.mem_wr_en && stall_left > 0) begin
                bus.mem_ready = 1'b0;
                if (!snapped) begin
                    snap_a  = bus.mem_addr;
                    snap_d  = bus.mem_wdata;
                    snapped = 1'b1;
                end else begin
                    check({tag, "_stall_addr_stable"},  64'(bus.mem_addr),  64'(snap_a));
                    check({tag, "_stall_wdata_stable"}, 64'(bus.mem_wdata), 64'(snap_d));
                end
                check({tag, "_stall_in_ready"}, 64'(bus.in_ready), 64'd0);
                stall_left--;
            end else if (ready_mode == 1) begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.mem_ready = 1'b1;
            end
            if (bus.in_ready && bus.in_valid) idx++;
            prev_final = 1'b0;
            if (bus.mem_wr_en && bus.mem_ready) begin
                got_data.push_back(bus.mem_wdata);
                got_addr.push_back(bus.mem_addr);
                prev_final = (got_data.size() == nwords);
            end
            @(negedge clk);
            cycles++;
        end
        done_seen = bus.done;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.mem_ready = 1'b1;
        check({tag, "_done_reached"},     64'(done_seen),       64'd1);
        check({tag, "_done_after_write"}, 64'(prev_final),      64'd1);
        check({tag, "_num_writes"},       64'(got_data.size()), 64'(nwords));
        check({tag, "_num_consumed"},     64'(idx),             64'(n));
        if (ready_mode == 2) check({tag, "_stall_happened"}, 64'(stall_left), 64'd0);
        for (int w = 0; w < nwords && w < got_data.size(); w++) begin
            check($sformatf("%s_w%0d_addr", tag, w), 64'(got_addr[w]), 64'(exp_addr[w]));
            check($sformatf("%s_w%0d_data", tag, w), 64'(got_data[w]), 64'(exp_data[w]));
        end
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(bus.done),      64'd0);
        check({tag, "_idle_busy"},      64'(bus.busy),      64'd0);
        check({tag, "_idle_wr_en"},     64'(bus.mem_wr_en), 64'd0);
    endtask

    task automatic reset_mid(input string tag, input int n_after);
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 16'h0400; bus.num_results = 12'd8;
        bus.in_valid = 1'b0; bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 24'(32'h7FF);
        check({tag, "_collect_ready"}, 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_data = 24'(32'hFF0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero({tag, "_reset"});
        rst = 1'b0;
        fill_random(n_after);
        run_layer({tag, "_fresh"}, 16'h0500, n_after, 0, 1'b0);
    endtask

    initial begin
        int d_cnt, w_cnt;
        rst = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.num_results = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("por");
        rst = 1'b0;

        // Full words, back-to-back
        stim_q.delete();
        for (int i = 1; i <= 8; i++) stim_q.push_back(16 * i);
        run_layer("full", 16'h0100, 8, 0, 1'b0);
        if (got_data.size() == 2) begin
            check("full_const_w0", 64'(got_data[0]), 64'h04030201);
            check("full_const_w1", 64'(got_data[1]), 64'h08070605);
            check("full_const_a1", 64'(got_addr[1]), 64'h0101);
        end else begin
            check("full_const_count", 64'(got_data.size()), 64'd2);
        end

        // Partial flush
        fill_random(43);
        run_layer("partial", 16'h0200, 43, 1, 1'b0);
        if (got_data.size() == 11) begin
            check("partial_last_pad",  64'(got_data[10] >> 24), 64'd0);
            check("partial_last_addr", 64'(got_addr[10]),       64'h020A);
        end

        // Saturation / ReLU
        stim_q = '{-100, 5000, 4095, 15};
        run_layer("sat", 16'h0300, 4, 0, 1'b0);
        if (got_data.size() == 1) check("sat_const", 64'(got_data[0]), 64'h00FFFF00);

        // Backpressure on the first write
        fill_random(8);
        run_layer("bp", 16'h0600, 8, 2, 1'b0);

        // Reset mid-layer, then clean restarts (full word and partial word)
        reset_mid("rstmid4", 4);
        reset_mid("rstmid3", 3);

        // num_results == 0
        @(negedge clk);
        bus.start = 1'b1; bus.num_results = 12'd0; bus.base_addr = 16'h1234;
        @(negedge clk);
        bus.start = 1'b0;
        check("zero_busy", 64'(bus.busy), 64'd1);
        d_cnt = 0; w_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.done) d_cnt++;
            if (bus.mem_wr_en) w_cnt++;
            @(negedge clk);
        end
        check("zero_done_pulses", 64'(d_cnt), 64'd1);
        check("zero_writes",      64'(w_cnt), 64'd0);

        // Start pulse during COLLECT must be ignored
        fill_random(12);
        run_layer("glitch", 16'h0700, 12, 1, 1'b1);

        // Address wrap
        fill_random(20);
        run_layer("wrap", 16'hFFFE, 20, 1, 1'b0);

        // Random layers
        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(1, 30));
            fill_random(n);
            run_layer($sformatf("rand%0d", r), 16'($urandom), n, 1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
